iir_decim_out: RTL and testbench
================================

Name: iir_decim_out

Overview:
- Output stage directly downstream of the cascaded second-order-section IIR filter.
- Consumes the filter's fixed-point output, which is signed and scaled by 2^FAC, one sample per clock when qualified.
- Decimates by DECIM, then rounds away the FAC fraction bits and saturates to OUT_WIDTH.
- Buffers results in a small FIFO and presents them to the consumer on a valid/ready handshake.

Parameters:
- BITWIDTH, 32: width of the filter output word (signed two's complement).
- FAC, 20: number of fraction bits to remove. Must be at least 1.
- OUT_WIDTH, 16: width of the output sample (signed). Must not exceed BITWIDTH-FAC+1.
- DECIM, 4: keep 1 of every DECIM accepted input samples. Must be at least 1; DECIM=1 disables decimation.
- DEPTH, 8: FIFO depth in entries. Must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- x  in  BITWIDTH  filter output sample (the filter's y).
- x_valid  in  1  x is a new sample this cycle. Tie high for a free-running filter.
- out_data  out  OUT_WIDTH  rounded, saturated sample at the FIFO head.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data this cycle.
- level  out  clog2(DEPTH)+1  current FIFO occupancy.
- sat  out  1  sticky flag: a kept sample was saturated.
- ovf  out  1  sticky flag: a converted sample was dropped because the FIFO was full.
- flag_clr  in  1  synchronous clear of sat and ovf.

Behaviour:
- Reset (rst=0, asynchronous):
  - Decimation counter=0, pipeline valids=0, FIFO pointers=0.
  - out_data=0, out_valid=0, level=0, sat=0, ovf=0.
  - Reset mid-operation discards all pipeline and FIFO contents immediately.
- Decimation counter (cnt):
  - Range 0..DECIM-1; advances only on x_valid=1.
  - A sample is kept when x_valid=1 and cnt==DECIM-1; cnt then wraps to 0.
  - So the first kept sample is the DECIM-th valid input after reset.
- Pipeline stage S1 (registered):
  - sum = sign-extend(x) to BITWIDTH+1 bits, plus 2^(FAC-1).
  - This is round-half-up; the extra bit prevents overflow at the positive limit.
  - v1 = kept.
- Pipeline stage S2 (registered):
  - q = sum arithmetically shifted right by FAC.
  - If q > 2^(OUT_WIDTH-1)-1, clamp to that maximum. If q < -2^(OUT_WIDTH-1), clamp to that minimum.
  - v2 = v1.
  - sat is set the cycle after S2 holds a clamped valid sample.
- FIFO push: when v2=1.
  - If the FIFO is full and no pop occurs this cycle: drop the sample and set ovf.
  - Otherwise write the sample.
- FIFO pop: when out_valid && out_ready.
  - out_data shows the head combinationally from registered storage.
  - While out_valid=1 and out_ready=0, out_data must hold stable.
- Simultaneous push and pop:
  - When full: both succeed, level is unchanged, no ovf.
  - When empty: the pushed sample becomes visible on the next cycle; no bypass.
- Latency: kept sample at cycle T → written to the FIFO at the end of cycle T+2 → out_valid=1 in cycle T+3 (FIFO was empty).
- Throughput: one kept sample per clock (DECIM=1) is sustained while out_ready=1.
- flag_clr clears sat and ovf. If a set event occurs in the same cycle, the set wins.
- level:
  - Increments on push-only, decrements on pop-only.
  - Wraps never; it saturates at DEPTH by construction.
- Pointers: log2(DEPTH)-bit pointers plus full/empty derived from level; wrap naturally at DEPTH.

Decomposition:
- Shared package iir_pkg:
  - round/saturate helper function: round_sat(value, FAC, OUT_WIDTH).
  - Constants for default FAC and BITWIDTH, shared with the filter sections.
- One sub-module: iir_sync_fifo.
  - Parameters: WIDTH, DEPTH.
  - Ports: clk, rst, push, din, pop, dout, empty, full, level.
- This module holds the decimation counter, the S1/S2 pipeline and the flags.

Test Plan:
- Reset/idle: rst low mid-stream with 3 entries queued → out_valid=0, level=0 and sat=ovf=0 immediately; no output until DECIM new valids.
- Rounding: FAC=20, DECIM=1.
  - x=3670016 (3.5) → out_data=4.
  - x=-3670016 → -3.
  - x=1048575 → 1.
  - x=524287 → 0.
  - Each appears 3 cycles after input.
- Saturation: OUT_WIDTH=8.
  - x=209715200 (200.0) → 127, sat=1.
  - x=-209715200 → -128.
  - flag_clr → sat=0.
- Decimation: DECIM=4, x=k*2^20 for k=1..12 with x_valid gaps → outputs exactly 4, 8, 12, in order.
- Backpressure/overflow: DEPTH=8, DECIM=1, out_ready=0, 10 valid samples 1..10 → level=8, ovf=1. Then out_ready=1 drains 1..8 with data stable while stalled.
- Full push+pop: FIFO full, push and pop in the same cycle → level stays 8, no ovf, and the new sample is read last.

Source files
------------

// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared constants and round/saturate helper for the IIR filter chain
package iir_pkg;

    localparam int DEFAULT_BITWIDTH = 32;
    localparam int DEFAULT_FAC      = 20;

    // value must already carry the half-LSB offset (2^(fac-1)); this drops the
    // fraction bits with an arithmetic shift and clamps to a signed out_width range
    function automatic logic signed [63:0] round_sat(
        input logic signed [63:0] value,
        input int                 fac,
        input int                 out_width
    );
        logic signed [63:0] q;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        q  = value >>> fac;
        hi = (64'sd1 <<< (out_width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_width - 1));
        if (q > hi) begin
            return hi;
        end else if (q < lo) begin
            return lo;
        end
        return q;
    endfunction

endpackage

// File: rtl/iir_sync_fifo.sv
// rtl/iir_sync_fifo.sv - synchronous FIFO with level count and combinational head
module iir_sync_fifo import iir_pkg::*; #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    // a full FIFO can still take a write when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);
    // no bypass: an empty FIFO shows zero even while a push is landing
    assign dout    = empty ? '0 : mem[rd_ptr];

    // storage write; the array needs no reset since empty masks stale entries
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/iir_decim_out.sv
// rtl/iir_decim_out.sv - decimate, round, saturate and queue the IIR filter output
module iir_decim_out import iir_pkg::*; #(
    parameter int BITWIDTH  = DEFAULT_BITWIDTH,
    parameter int FAC       = DEFAULT_FAC,
    parameter int OUT_WIDTH = 16,
    parameter int DECIM     = 4,
    parameter int DEPTH     = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [BITWIDTH-1:0]  x,
    input  logic                        x_valid,
    output logic [OUT_WIDTH-1:0]        out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        sat,
    output logic                        ovf,
    input  logic                        flag_clr
);

    localparam int                      CW       = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CW-1:0]           CNT_LAST = CW'(DECIM - 1);
    localparam logic signed [BITWIDTH:0] HALF    = (BITWIDTH + 1)'(1) << (FAC - 1);

    logic [CW-1:0]              cnt;
    logic                       keep;
    logic signed [BITWIDTH:0]   sum1;
    logic                       v1;
    logic signed [63:0]         sum_ext;
    logic signed [63:0]         q_shift;
    logic signed [63:0]         q_clamp;
    logic                       clip;
    logic [OUT_WIDTH-1:0]       q2;
    logic                       v2;
    logic                       clip2;
    logic                       fifo_empty;
    logic                       fifo_full;
    logic                       pop;
    logic                       push;

    assign keep      = x_valid && (cnt == CNT_LAST);
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign push      = v2 && (!fifo_full || pop);

    // decimation counter: counts accepted samples, wraps on the kept one
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (x_valid) begin
            cnt <= keep ? '0 : cnt + 1'b1;
        end
    end

    // S1: add the half-LSB in one extra bit so the positive limit cannot wrap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum1 <= '0;
            v1   <= 1'b0;
        end else begin
            v1 <= keep;
            if (keep) begin
                sum1 <= $signed({x[BITWIDTH-1], x}) + HALF;
            end
        end
    end

    // shift and clamp; clip marks a sample whose value was altered by the clamp
    always_comb begin
        sum_ext = 64'(sum1);
        q_shift = sum_ext >>> FAC;
        q_clamp = round_sat(sum_ext, FAC, OUT_WIDTH);
        clip    = (q_clamp != q_shift);
    end

    // S2: register the converted sample ahead of the FIFO
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q2    <= '0;
            v2    <= 1'b0;
            clip2 <= 1'b0;
        end else begin
            v2    <= v1;
            clip2 <= clip;
            if (v1) begin
                q2 <= q_clamp[OUT_WIDTH-1:0];
            end
        end
    end

    // sticky flags; a set event in the same cycle as flag_clr takes priority
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat <= 1'b0;
            ovf <= 1'b0;
        end else begin
            if (flag_clr) begin
                sat <= 1'b0;
                ovf <= 1'b0;
            end
            if (v2 && clip2) begin
                sat <= 1'b1;
            end
            if (v2 && fifo_full && !pop) begin
                ovf <= 1'b1;
            end
        end
    end

    iir_sync_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (q2),
        .pop   (pop),
        .dout  (out_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (level)
    );

endmodule

// File: tb/tb_iir_decim_out.sv
// tb/tb_iir_decim_out.sv - self-checking bench for iir_decim_out
module tb_iir_decim_out;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic signed [31:0] xa, xb;
    logic               va, vb, ra, rb, ca, cb;
    logic [7:0]         da;
    logic [15:0]        db;
    logic               ova, ovb;
    logic [3:0]         la, lb;
    logic               sa, sb, oa, ob;

    int     checks = 0;
    int     errors = 0;
    longint got_b[$];
    logic   collect_b = 1'b0;

    typedef struct {
        logic signed [31:0] x;
        logic signed [7:0]  q;
        logic               s;
    } rvec_t;

    rvec_t tbl[10];

    iir_decim_out #(
        .BITWIDTH(32), .FAC(20), .OUT_WIDTH(8), .DECIM(1), .DEPTH(8)
    ) dut_a (
        .clk(clk), .rst(rst), .x(xa), .x_valid(va),
        .out_data(da), .out_valid(ova), .out_ready(ra),
        .level(la), .sat(sa), .ovf(oa), .flag_clr(ca)
    );

    iir_decim_out #(
        .BITWIDTH(32), .FAC(20), .OUT_WIDTH(16), .DECIM(4), .DEPTH(8)
    ) dut_b (
        .clk(clk), .rst(rst), .x(xb), .x_valid(vb),
        .out_data(db), .out_valid(ovb), .out_ready(rb),
        .level(lb), .sat(sb), .ovf(ob), .flag_clr(cb)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (collect_b && ovb && rb) got_b.push_back(longint'($signed(db)));
    endtask

    initial begin
        tbl[0] = '{32'sd3670016,    8'sd4,    1'b0};
        tbl[1] = '{-32'sd3670016,   -8'sd3,   1'b0};
        tbl[2] = '{32'sd1048575,    8'sd1,    1'b0};
        tbl[3] = '{32'sd524287,     8'sd0,    1'b0};
        tbl[4] = '{32'sd524288,     8'sd1,    1'b0};
        tbl[5] = '{-32'sd524288,    8'sd0,    1'b0};
        tbl[6] = '{-32'sd524289,    -8'sd1,   1'b0};
        tbl[7] = '{32'sd209715200,  8'sd127,  1'b1};
        tbl[8] = '{-32'sd209715200, -8'sd128, 1'b1};
        tbl[9] = '{32'sd2147483647, 8'sd127,  1'b1};

        rst = 1'b0;
        xa = '0; xb = '0; va = 0; vb = 0; ra = 0; rb = 0; ca = 0; cb = 0;
        tick(); tick();
        check("rst_data_a", longint'(da), 0);
        check("rst_valid_a", longint'(ova), 0);
        check("rst_level_a", longint'(la), 0);
        check("rst_sat_a", longint'(sa), 0);
        check("rst_ovf_a", longint'(oa), 0);
        check("rst_valid_b", longint'(ovb), 0);
        check("rst_level_b", longint'(lb), 0);
        rst = 1'b1;
        tick();

        // rounding / saturation table, flag_clr asserted alongside each set event
        for (int i = 0; i < 10; i++) begin
            xa = tbl[i].x; va = 1;
            tick();
            va = 0; xa = '0;
            tick();
            check("round_early", longint'(ova), 0);
            ca = 1;
            tick();
            ca = 0;
            check("round_valid", longint'(ova), 1);
            check("round_data", longint'($signed(da)), longint'(tbl[i].q));
            check("round_sat", longint'(sa), longint'(tbl[i].s));
            ra = 1;
            tick();
            ra = 0;
            check("round_drained", longint'(la), 0);
        end
        ca = 1;
        tick();
        ca = 0;
        check("sat_clr", longint'(sa), 0);

        // decimation by 4 with gaps in x_valid
        rb = 1; collect_b = 1;
        for (int k = 1; k <= 12; k++) begin
            xb = k * 1048576; vb = 1;
            tick();
            if (k % 3 == 0) begin
                vb = 0; xb = 999 * 1048576;
                tick();
            end
        end
        vb = 0;
        repeat (6) tick();
        collect_b = 0; rb = 0;
        check("dec_count", longint'(got_b.size()), 3);
        for (int i = 0; i < 3; i++) begin
            check("dec_data", (i < got_b.size()) ? got_b[i] : -1, longint'((i + 1) * 4));
        end

        // backpressure and overflow
        ra = 0;
        for (int k = 1; k <= 10; k++) begin
            xa = k * 1048576; va = 1;
            tick();
        end
        va = 0;
        repeat (3) tick();
        check("bp_level", longint'(la), 8);
        check("bp_ovf", longint'(oa), 1);
        check("bp_stall0", longint'($signed(da)), 1);
        tick();
        check("bp_stall1", longint'($signed(da)), 1);
        ra = 1;
        for (int i = 1; i <= 8; i++) begin
            check("bp_valid", longint'(ova), 1);
            check("bp_drain", longint'($signed(da)), longint'(i));
            tick();
        end
        ra = 0;
        check("bp_empty", longint'(ova), 0);
        check("bp_level0", longint'(la), 0);

        // push and pop together while full
        ca = 1;
        tick();
        ca = 0;
        check("ovf_clr", longint'(oa), 0);
        for (int k = 1; k <= 9; k++) begin
            xa = k * 1048576; va = 1;
            tick();
        end
        va = 0;
        tick();
        check("fpp_full", longint'(la), 8);
        check("fpp_head", longint'($signed(da)), 1);
        ra = 1;
        tick();
        ra = 0;
        check("fpp_level", longint'(la), 8);
        check("fpp_no_ovf", longint'(oa), 0);
        ra = 1;
        for (int i = 2; i <= 9; i++) begin
            check("fpp_drain", longint'($signed(da)), longint'(i));
            tick();
        end
        ra = 0;
        check("fpp_empty", longint'(la), 0);

        // asynchronous reset mid-stream
        xa = 32'sd209715200; va = 1;
        tick();
        va = 0;
        repeat (3) tick();
        check("pre_sat", longint'(sa), 1);
        rb = 0;
        for (int k = 1; k <= 12; k++) begin
            xb = k * 1048576; vb = 1;
            tick();
        end
        vb = 0;
        repeat (4) tick();
        check("pre_level_b", longint'(lb), 3);
        #2 rst = 1'b0;
        #1;
        check("ar_valid_b", longint'(ovb), 0);
        check("ar_level_b", longint'(lb), 0);
        check("ar_level_a", longint'(la), 0);
        check("ar_valid_a", longint'(ova), 0);
        check("ar_sat_a", longint'(sa), 0);
        check("ar_ovf_a", longint'(oa), 0);
        #1 rst = 1'b1;
        tick();
        for (int k = 21; k <= 23; k++) begin
            xb = k * 1048576; vb = 1;
            tick();
        end
        vb = 0;
        repeat (5) tick();
        check("ar_no_early", longint'(ovb), 0);
        xb = 24 * 1048576; vb = 1;
        tick();
        vb = 0;
        tick(); tick();
        check("ar_first_valid", longint'(ovb), 1);
        check("ar_first_data", longint'($signed(db)), 24);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
